// File: rtl/add_sub_pipe.sv
// rtl/add_sub_pipe.sv - pipelined signed/unsigned adder-subtractor with valid/ready handshake
// Optional saturation of signed overflow enabled by defining ADD_SUB_PIPE_SAT_EN.
module add_sub_pipe #(
    parameter int NBITS  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [NBITS-1:0] A,
    input  logic [NBITS-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] Result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int W = NBITS / STAGES;
    localparam int L = STAGES - 1;

    logic [STAGES-1:0] vld, en, v_s, c_s, c_n, c_q;
    logic [NBITS-1:0]  a_q   [STAGES];
    logic [NBITS-1:0]  bx_q  [STAGES];
    logic [NBITS-1:0]  sum_q [STAGES];
    logic [NBITS-1:0]  a_s   [STAGES];
    logic [NBITS-1:0]  bx_s  [STAGES];
    logic [NBITS-1:0]  sum_s [STAGES];
    logic [NBITS-1:0]  sum_n [STAGES];
    logic [1:0]        op_q  [STAGES];
    logic [1:0]        op_s  [STAGES];

    logic             en_out;
    logic [NBITS-1:0] res_n;
    logic             carry_n, ovf_n, a_msb, bx_msb, s_msb;

    // Stage k consumes the carry of stage k-1 and fills in slice k of the running sum.
    always_comb begin : slices
        logic [W:0] part;
        part     = '0;
        v_s[0]   = in_valid;
        a_s[0]   = A;
        bx_s[0]  = op[1] ? ~B : B;
        sum_s[0] = '0;
        c_s[0]   = op[1];
        op_s[0]  = op;
        for (int k = 1; k < STAGES; k++) begin
            v_s[k]   = vld[k-1];
            a_s[k]   = a_q[k-1];
            bx_s[k]  = bx_q[k-1];
            sum_s[k] = sum_q[k-1];
            c_s[k]   = c_q[k-1];
            op_s[k]  = op_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            part     = {1'b0, a_s[k][k*W +: W]} + {1'b0, bx_s[k][k*W +: W]} + {{W{1'b0}}, c_s[k]};
            sum_n[k] = sum_s[k];
            sum_n[k][k*W +: W] = part[W-1:0];
            c_n[k]   = part[W];
        end
    end

    always_comb begin
        a_msb   = a_q[L][NBITS-1];
        bx_msb  = bx_q[L][NBITS-1];
        s_msb   = sum_q[L][NBITS-1];
        ovf_n   = ~op_q[L][0] & (a_msb == bx_msb) & (s_msb != a_msb);
        carry_n = c_q[L] ^ op_q[L][1];
        res_n   = sum_q[L];
`ifdef ADD_SUB_PIPE_SAT_EN
        if (ovf_n) begin
            res_n = a_msb ? {1'b1, {(NBITS-1){1'b0}}} : {1'b0, {(NBITS-1){1'b1}}};
        end
`endif
    end

    // A stage may load when it is empty or when everything downstream moves this cycle.
    always_comb begin
        en_out = ~out_valid | out_ready;
        en     = '0;
        en[L]  = ~vld[L] | en_out;
        for (int k = STAGES - 2; k >= 0; k--) begin
            en[k] = ~vld[k] | en[k+1];
        end
    end

    assign in_ready = en[0] & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld       <= '0;
            c_q       <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                bx_q[k]  <= '0;
                sum_q[k] <= '0;
                op_q[k]  <= '0;
            end
            out_valid <= 1'b0;
            Result    <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (en[k]) begin
                    vld[k] <= v_s[k];
                    if (v_s[k]) begin
                        a_q[k]   <= a_s[k];
                        bx_q[k]  <= bx_s[k];
                        sum_q[k] <= sum_n[k];
                        c_q[k]   <= c_n[k];
                        op_q[k]  <= op_s[k];
                    end
                end
            end
            if (en_out) begin
                out_valid <= vld[L];
                if (vld[L]) begin
                    Result   <= res_n;
                    carry    <= carry_n;
                    overflow <= ovf_n;
                    zero     <= ~|res_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_add_sub_pipe.sv
// tb/tb_add_sub_pipe.sv - directed and streaming checks of add_sub_pipe at STAGES=2 and STAGES=4
module tb_add_sub_pipe;

`ifdef ADD_SUB_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   failures = 0;

    logic        p2_in_valid = 1'b0, p2_in_ready, p2_out_valid, p2_out_ready = 1'b0;
    logic [1:0]  p2_op = '0;
    logic [31:0] p2_a = '0, p2_b = '0, p2_result;
    logic        p2_carry, p2_ovf, p2_zero;

    logic        p4_in_valid = 1'b0, p4_in_ready, p4_out_valid, p4_out_ready = 1'b0;
    logic [1:0]  p4_op = '0;
    logic [31:0] p4_a = '0, p4_b = '0, p4_result;
    logic        p4_carry, p4_ovf, p4_zero;

    always #5 clk = ~clk;

    add_sub_pipe #(.NBITS(32), .STAGES(2)) u_p2 (
        .clk(clk), .reset(reset), .in_valid(p2_in_valid), .in_ready(p2_in_ready), .op(p2_op),
        .A(p2_a), .B(p2_b), .out_valid(p2_out_valid), .out_ready(p2_out_ready),
        .Result(p2_result), .carry(p2_carry), .overflow(p2_ovf), .zero(p2_zero)
    );

    add_sub_pipe #(.NBITS(32), .STAGES(4)) u_p4 (
        .clk(clk), .reset(reset), .in_valid(p4_in_valid), .in_ready(p4_in_ready), .op(p4_op),
        .A(p4_a), .B(p4_b), .out_valid(p4_out_valid), .out_ready(p4_out_ready),
        .Result(p4_result), .carry(p4_carry), .overflow(p4_ovf), .zero(p4_zero)
    );

    // Reference: {carry, overflow, zero, result} from plain 33-bit arithmetic.
    function automatic logic [34:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        logic        c, v;
        if (o[1]) begin
            w = {1'b0, a} - {1'b0, b};
            c = (a < b);
            v = (a[31] != b[31]) && (w[31] != a[31]);
        end else begin
            w = {1'b0, a} + {1'b0, b};
            c = w[32];
            v = (a[31] == b[31]) && (w[31] != a[31]);
        end
        if (o[0]) v = 1'b0;
        r = w[31:0];
        if (SAT && v) r = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return {c, v, (r == 32'd0), r};
    endfunction

    task automatic test_reset();
        #3;
        tests++; if (p2_in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready_p2 got %b want 0", p2_in_ready); end
        tests++; if (p4_in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready_p4 got %b want 0", p4_in_ready); end
        tests++; if (p2_out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got %b want 0", p2_out_valid); end
        tests++; if ({p2_result, p2_carry, p2_ovf, p2_zero} !== 35'd0) begin
            failures++; $display("FAIL rst_outputs got %h %b%b%b want 0", p2_result, p2_carry, p2_ovf, p2_zero); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        tests++; if (p2_in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_p2 got %b want 1", p2_in_ready); end
        tests++; if (p4_in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_p4 got %b want 1", p4_in_ready); end
    endtask

    task automatic test_basic();
        logic [1:0]  t_op [10];
        logic [31:0] t_a [10];
        logic [31:0] t_b [10];
        logic [31:0] e_r [10];
        logic [2:0]  e_f [10];
        t_op = '{2'b00, 2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b11, 2'b01, 2'b00, 2'b01};
        t_a  = '{32'd5, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'h8000_0000, 32'd9, 32'd0,
                 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};
        t_b  = '{32'd7, 32'd1, 32'd1, 32'd5, 32'd1, 32'd9, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'd1};
        e_r  = '{32'd12, SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 32'd0, 32'hFFFF_FFFE,
                 SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000,
                 32'hFFFF_FFFE, 32'h0001_0000};
        // {carry, overflow, zero}
        e_f  = '{3'b000, 3'b010, 3'b101, 3'b100, 3'b010, 3'b001, 3'b100, 3'b000, 3'b100, 3'b000};
        p2_out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            p2_in_valid = 1'b1; p2_op = t_op[i]; p2_a = t_a[i]; p2_b = t_b[i];
            #1;
            tests++; if (p2_in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready[%0d] got %b want 1", i, p2_in_ready); end
            @(negedge clk);
            p2_in_valid = 1'b0; p2_op = 2'($urandom_range(0, 3)); p2_a = $urandom; p2_b = $urandom;
            #1;
            tests++; if (p2_out_valid !== 1'b0) begin failures++; $display("FAIL basic_lat1[%0d] got %b want 0", i, p2_out_valid); end
            @(negedge clk); #1;
            tests++; if (p2_out_valid !== 1'b0) begin failures++; $display("FAIL basic_lat2[%0d] got %b want 0", i, p2_out_valid); end
            @(negedge clk); #1;
            tests++; if (p2_out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid[%0d] got %b want 1", i, p2_out_valid); end
            tests++; if (p2_result !== e_r[i]) begin failures++; $display("FAIL basic_result[%0d] got %h want %h", i, p2_result, e_r[i]); end
            tests++; if ({p2_carry, p2_ovf, p2_zero} !== e_f[i]) begin
                failures++; $display("FAIL basic_flags[%0d] got cvz=%b%b%b want %b", i, p2_carry, p2_ovf, p2_zero, e_f[i]); end
            @(negedge clk); #1;
            tests++; if (p2_out_valid !== 1'b0) begin failures++; $display("FAIL basic_drain[%0d] got %b want 0", i, p2_out_valid); end
        end
    endtask

    task automatic test_back_pressure();
        logic [1:0]  b_op [6];
        logic [31:0] b_a [6];
        logic [31:0] b_b [6];
        logic [34:0] ex [6];
        int acc = 0, got = 0, last_c = 0;
        for (int i = 0; i < 6; i++) begin
            b_op[i] = 2'(i % 4);
            b_a[i]  = 32'h0001_0000 * (i + 1) + i;
            b_b[i]  = 32'h0000_F000 + i * 5;
            ex[i]   = model(b_op[i], b_a[i], b_b[i]);
        end
        for (int c = 0; c < 40 && got < 6; c++) begin
            @(negedge clk);
            p2_in_valid = (acc < 6);
            if (acc < 6) begin p2_op = b_op[acc]; p2_a = b_a[acc]; p2_b = b_b[acc]; end
            p2_out_ready = (c >= 8);
            #1;
            if (c == 7) begin
                tests++; if (acc != 3) begin failures++; $display("FAIL bp_accepts got %0d want 3", acc); end
                tests++; if (p2_in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got %b want 0", p2_in_ready); end
            end
            if (c == 8) begin
                tests++; if (p2_in_ready !== 1'b1) begin failures++; $display("FAIL bp_pass_ready got %b want 1", p2_in_ready); end
            end
            if (c >= 3 && c < 8) begin
                tests++; if (p2_out_valid !== 1'b1 || p2_result !== ex[0][31:0]) begin
                    failures++; $display("FAIL bp_hold c=%0d got v=%b %h want v=1 %h", c, p2_out_valid, p2_result, ex[0][31:0]); end
            end
            if (p2_out_valid && p2_out_ready) begin
                tests++; if ({p2_carry, p2_ovf, p2_zero, p2_result} !== ex[got]) begin
                    failures++; $display("FAIL bp_result[%0d] got %b%b%b %h want %h", got, p2_carry, p2_ovf, p2_zero, p2_result, ex[got]); end
                if (got > 0) begin
                    tests++; if (c != last_c + 1) begin failures++; $display("FAIL bp_rate[%0d] got cycle %0d want %0d", got, c, last_c + 1); end
                end
                last_c = c;
                got++;
            end
            if (p2_in_valid && p2_in_ready) acc++;
        end
        p2_in_valid = 1'b0;
        tests++; if (got != 6) begin failures++; $display("FAIL bp_count got %0d want 6", got); end
        @(negedge clk); #1;
        tests++; if (p2_out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_dup got %b want 0", p2_out_valid); end
    endtask

    task automatic test_full_rate();
        logic [34:0] exq[$];
        int          tq[$];
        int          t0;
        logic [34:0] e;
        p4_out_ready = 1'b1;
        for (int c = 0; c < 215; c++) begin
            @(negedge clk);
            p4_in_valid = (c < 200);
            p4_op = 2'($urandom_range(0, 3));
            p4_a  = (c % 7 == 0) ? 32'hFFFF_FFFF : $urandom;
            p4_b  = (c % 5 == 0) ? 32'd1 : $urandom;
            #1;
            if (c < 200) begin
                tests++; if (p4_in_ready !== 1'b1) begin failures++; $display("FAIL fr_ready c=%0d got %b want 1", c, p4_in_ready); end
            end
            if (p4_out_valid) begin
                tests++;
                if (exq.size() == 0) begin
                    failures++; $display("FAIL fr_spurious c=%0d got out_valid=1 want 0", c);
                end else begin
                    e  = exq.pop_front();
                    t0 = tq.pop_front();
                    if ({p4_carry, p4_ovf, p4_zero, p4_result} !== e || c - t0 != 5) begin
                        failures++; $display("FAIL fr_result c=%0d got %b%b%b %h lat %0d want %h lat 5",
                                             c, p4_carry, p4_ovf, p4_zero, p4_result, c - t0, e); end
                end
            end
            if (p4_in_valid && p4_in_ready) begin
                exq.push_back(model(p4_op, p4_a, p4_b));
                tq.push_back(c);
            end
        end
        tests++; if (exq.size() != 0) begin failures++; $display("FAIL fr_lost got %0d pending want 0", exq.size()); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        p4_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            p4_in_valid = 1'b1; p4_op = 2'b01;
            p4_a = (i == 0) ? 32'hFFFF_FFFF : 32'd100 + i; p4_b = (i == 0) ? 32'd2 : 32'd7;
        end
        @(negedge clk);
        p4_in_valid = 1'b0;
        for (int c = 0; c < 10 && !p4_out_valid; c++) @(negedge clk);
        #1;
        tests++; if (p4_out_valid !== 1'b1 || p4_result !== 32'd1 || p4_carry !== 1'b1) begin
            failures++; $display("FAIL rm_pre got v=%b %h c=%b want v=1 00000001 c=1", p4_out_valid, p4_result, p4_carry); end
        #2;
        reset = 1'b1;
        #1;
        tests++; if (p4_out_valid !== 1'b0) begin failures++; $display("FAIL rm_out_valid got %b want 0", p4_out_valid); end
        tests++; if ({p4_result, p4_carry, p4_ovf, p4_zero} !== 35'd0) begin
            failures++; $display("FAIL rm_outputs got %h %b%b%b want 0", p4_result, p4_carry, p4_ovf, p4_zero); end
        tests++; if (p4_in_ready !== 1'b0) begin failures++; $display("FAIL rm_in_ready got %b want 0", p4_in_ready); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        p4_out_ready = 1'b1;
        #1;
        tests++; if (p4_in_ready !== 1'b1) begin failures++; $display("FAIL rm_release got %b want 1", p4_in_ready); end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); #1;
            if (p4_out_valid) seen++;
        end
        tests++; if (seen != 0) begin failures++; $display("FAIL rm_stale got %0d results want 0", seen); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_back_pressure();
        test_full_rate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
